// File: rtl/gwa_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : gwa_change_dispenser
// Brief    : Coin-credit change machine with paced C10/C20 payout.
//            Optional RF refund key enabled by the GWA_REFUND_EN macro.
// Revision : 1.0  initial release
// ============================================================================
module gwa_change_dispenser #(
  parameter int MAX_EUR  = 10,
  parameter int CREDIT_W = 8,
  parameter int MIX_C10  = 2,
  parameter int GAP      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                EU1,
  input  logic                EU2,
  input  logic                WT,
`ifdef GWA_REFUND_EN
  input  logic                RF,
`endif
  output logic                C10_O,
  output logic                C20_O,
  output logic                EU1_O,
  output logic                EU2_O,
  output logic [CREDIT_W-1:0] CREDIT,
  output logic                BUSY
);

  localparam int                AW      = CREDIT_W + 1;
  localparam logic [AW-1:0]     LIMIT   = AW'(MAX_EUR * 10);
  localparam logic [AW-1:0]     EU1_VAL = AW'(10);
  localparam logic [AW-1:0]     EU2_VAL = AW'(20);
  localparam logic [CREDIT_W-1:0] C_ONE    = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] C_TWO    = CREDIT_W'(2);
  localparam logic [CREDIT_W-1:0] C_TEN    = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] C_TWENTY = CREDIT_W'(20);
  localparam logic [3:0]        MIX_LIM = 4'(MIX_C10);
  localparam logic [2:0]        GAP_LEN = 3'(GAP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PAY  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [3:0]          mix_q, mix_d;
  logic [2:0]          gap_q, gap_d;
  logic                refund_q, refund_d;
  logic                busy_q, busy_d;
  logic                c10_q, c10_d, c20_q, c20_d;
  logic                eu1o_q, eu1o_d, eu2o_q, eu2o_d;
  logic                eu1_prev_q, eu2_prev_q, wt_prev_q;
  logic                eu1_edge, eu2_edge, wt_edge, rf_edge;

  logic [AW-1:0]       acc;
  logic                pay_go, pay_ref;
  logic [CREDIT_W-1:0] pay_rem, rem_next;
  logic [3:0]          pay_mix;

  assign eu1_edge = EU1 & ~eu1_prev_q;
  assign eu2_edge = EU2 & ~eu2_prev_q;
  assign wt_edge  = WT  & ~wt_prev_q;

`ifdef GWA_REFUND_EN
  logic rf_prev_q;
  assign rf_edge = RF & ~rf_prev_q;

  always_ff @(posedge clk) begin
    if (rst) rf_prev_q <= 1'b0;
    else     rf_prev_q <= RF;
  end
`else
  assign rf_edge = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      credit_q   <= '0;
      mix_q      <= '0;
      gap_q      <= '0;
      refund_q   <= 1'b0;
      busy_q     <= 1'b0;
      c10_q      <= 1'b0;
      c20_q      <= 1'b0;
      eu1o_q     <= 1'b0;
      eu2o_q     <= 1'b0;
      eu1_prev_q <= 1'b0;
      eu2_prev_q <= 1'b0;
      wt_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      mix_q      <= mix_d;
      gap_q      <= gap_d;
      refund_q   <= refund_d;
      busy_q     <= busy_d;
      c10_q      <= c10_d;
      c20_q      <= c20_d;
      eu1o_q     <= eu1o_d;
      eu2o_q     <= eu2o_d;
      eu1_prev_q <= EU1;
      eu2_prev_q <= EU2;
      wt_prev_q  <= WT;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    mix_d    = mix_q;
    gap_d    = gap_q;
    refund_d = refund_q;
    busy_d   = 1'b0;
    c10_d    = 1'b0;
    c20_d    = 1'b0;
    eu1o_d   = 1'b0;
    eu2o_d   = 1'b0;
    acc      = {1'b0, credit_q};
    pay_go   = 1'b0;
    pay_ref  = refund_q;
    pay_rem  = credit_q;
    pay_mix  = mix_q;
    rem_next = credit_q;

    unique case (state_q)
      S_IDLE: begin
        // BUSY is still high in the cycle of the final pulse: keys there count as busy
        if (busy_q) begin
          eu1o_d = eu1_edge;
          eu2o_d = eu2_edge;
        end else begin
          if (eu2_edge) begin
            if (acc + EU2_VAL <= LIMIT) acc = acc + EU2_VAL;
            else                        eu2o_d = 1'b1;
          end
          if (eu1_edge) begin
            if (acc + EU1_VAL <= LIMIT) acc = acc + EU1_VAL;
            else                        eu1o_d = 1'b1;
          end
          credit_d = acc[CREDIT_W-1:0];
          pay_rem  = acc[CREDIT_W-1:0];
          pay_mix  = '0;
          pay_ref  = 1'b0;
          if (wt_edge && acc != '0) begin
            pay_go   = 1'b1;
            refund_d = 1'b0;
          end else if (rf_edge && acc != '0) begin
            pay_go   = 1'b1;
            pay_ref  = 1'b1;
            refund_d = 1'b1;
          end
        end
      end
      S_PAY: begin
        eu1o_d = eu1_edge;
        eu2o_d = eu2_edge;
        pay_go = 1'b1;
      end
      S_GAP: begin
        eu1o_d = eu1_edge;
        eu2o_d = eu2_edge;
        busy_d = 1'b1;
        if (gap_q <= 3'd1) state_d = S_PAY;
        else               gap_d   = gap_q - 3'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // One payout coin; shared by the WT/RF start in IDLE and every PAY visit
    if (pay_go) begin
      busy_d = 1'b1;
      mix_d  = pay_mix;
      if (pay_ref) begin
        if (pay_rem >= C_TWENTY) begin
          eu2o_d   = 1'b1;
          rem_next = pay_rem - C_TWENTY;
        end else if (pay_rem >= C_TEN) begin
          eu1o_d   = 1'b1;
          rem_next = pay_rem - C_TEN;
        end else begin
          rem_next = '0;
        end
      end else if (pay_mix < MIX_LIM && pay_rem != '0) begin
        c10_d    = 1'b1;
        rem_next = pay_rem - C_ONE;
        mix_d    = pay_mix + 4'd1;
      end else if (pay_rem >= C_TWO) begin
        c20_d    = 1'b1;
        rem_next = pay_rem - C_TWO;
      end else begin
        c10_d    = (pay_rem == C_ONE);
        rem_next = '0;
      end
      credit_d = rem_next;
      if (rem_next == '0) begin
        state_d = S_IDLE;
      end else if (GAP_LEN != 3'd0) begin
        state_d = S_GAP;
        gap_d   = GAP_LEN;
      end else begin
        state_d = S_PAY;
      end
    end
  end

  assign C10_O  = c10_q;
  assign C20_O  = c20_q;
  assign EU1_O  = eu1o_q;
  assign EU2_O  = eu2o_q;
  assign CREDIT = credit_q;
  assign BUSY   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_gwa_change_dispenser.sv
`default_nettype none
// Scoreboard bench: two parameterisations driven by the same keys, checked each
// cycle against a payout-schedule model.
module tb_gwa_change_dispenser;

  localparam int MAX0 = 10, MIX0 = 2, GAP0 = 1;
  localparam int MAX1 = 2,  MIX1 = 3, GAP1 = 0;

  logic clk = 1'b0;
  logic rst, eu1, eu2, wt;
  logic c10_0, c20_0, e1o_0, e2o_0, busy_0;
  logic c10_1, c20_1, e1o_1, e2o_1, busy_1;
  logic [7:0] credit_0, credit_1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // model state, index = DUT
  int m_credit[2], m_t0[2], m_base[2], m_n10a[2], m_n20[2], m_n10b[2];
  bit m_act[2], m_busy[2];
  bit p1, p2, pw;
  logic [12:0] q0[$];
  logic [12:0] q1[$];

  initial forever #5 clk = ~clk;

  gwa_change_dispenser #(.MAX_EUR(MAX0), .CREDIT_W(8), .MIX_C10(MIX0), .GAP(GAP0)) dut0 (
    .clk(clk), .rst(rst), .EU1(eu1), .EU2(eu2), .WT(wt),
`ifdef GWA_REFUND_EN
    .RF(1'b0),
`endif
    .C10_O(c10_0), .C20_O(c20_0), .EU1_O(e1o_0), .EU2_O(e2o_0),
    .CREDIT(credit_0), .BUSY(busy_0));

  gwa_change_dispenser #(.MAX_EUR(MAX1), .CREDIT_W(8), .MIX_C10(MIX1), .GAP(GAP1)) dut1 (
    .clk(clk), .rst(rst), .EU1(eu1), .EU2(eu2), .WT(wt),
`ifdef GWA_REFUND_EN
    .RF(1'b0),
`endif
    .C10_O(c10_1), .C20_O(c20_1), .EU1_O(e1o_1), .EU2_O(e2o_1),
    .CREDIT(credit_1), .BUSY(busy_1));

  // Total paid (10-cent units) after the first cnt coins of a payout
  function automatic int paid_upto(input int cnt, input int n10a, input int n20);
    if (cnt <= n10a) return cnt;
    if (cnt - n10a <= n20) return n10a + 2 * (cnt - n10a);
    return n10a + 2 * n20 + (cnt - n10a - n20);
  endfunction

  task automatic model_dut(input int d, input bit r, input bit ed1, input bit ed2,
                           input bit edw, output logic [12:0] rec);
    int lim, mix, g, c, j, n, k, last, rcred;
    bit rc10, rc20, re1, re2, rb;
    lim  = (d == 0) ? MAX0 * 10 : MAX1 * 10;
    mix  = (d == 0) ? MIX0 : MIX1;
    g    = (d == 0) ? GAP0 : GAP1;
    rc10 = 0; rc20 = 0; re1 = 0; re2 = 0; rb = 0; rcred = 0;
    if (r) begin
      m_act[d] = 0; m_credit[d] = 0; m_busy[d] = 0;
      rec = '0;
      return;
    end
    if (m_busy[d]) begin
      re1 = ed1;
      re2 = ed2;
    end else begin
      c = m_credit[d];
      if (ed2) begin
        if (c + 20 <= lim) c += 20; else re2 = 1;
      end
      if (ed1) begin
        if (c + 10 <= lim) c += 10; else re1 = 1;
      end
      m_credit[d] = c;
      if (edw && c > 0) begin
        m_act[d]  = 1;
        m_t0[d]   = cyc;
        m_base[d] = c;
        m_n10a[d] = (c < mix) ? c : mix;
        m_n20[d]  = (c - m_n10a[d]) / 2;
        m_n10b[d] = (c - m_n10a[d]) % 2;
      end
    end
    if (m_act[d]) begin
      j    = cyc - m_t0[d];
      n    = m_n10a[d] + m_n20[d] + m_n10b[d];
      last = (n - 1) * (g + 1);
      k    = j / (g + 1);
      rb   = 1;
      if (j % (g + 1) == 0) begin
        if (paid_upto(k + 1, m_n10a[d], m_n20[d]) - paid_upto(k, m_n10a[d], m_n20[d]) == 1)
          rc10 = 1;
        else
          rc20 = 1;
      end
      rcred = m_base[d] - paid_upto(k + 1, m_n10a[d], m_n20[d]);
      if (j >= last) begin
        m_act[d]    = 0;
        m_credit[d] = 0;
      end
    end else begin
      rcred = m_credit[d];
    end
    m_busy[d] = rb;
    rec = {rc10, rc20, re1, re2, rb, 8'(rcred)};
  endtask

  // Apply keys for one clock edge and queue what each DUT must show after it
  task automatic step(input bit r, input bit k1, input bit k2, input bit kw);
    logic [12:0] rec;
    bit ed1, ed2, edw;
    ed1 = k1 && !p1;
    ed2 = k2 && !p2;
    edw = kw && !pw;
    rst = r; eu1 = k1; eu2 = k2; wt = kw;
    model_dut(0, r, ed1, ed2, edw, rec);
    q0.push_back(rec);
    model_dut(1, r, ed1, ed2, edw, rec);
    q1.push_back(rec);
    if (r) begin
      p1 = 0; p2 = 0; pw = 0;
    end else begin
      p1 = k1; p2 = k2; pw = kw;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  task automatic compare(input int d, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d out@%0t: got c10,c20,eu1o,eu2o,busy=%b credit=%0d, expected %b credit=%0d",
               d, $time, act[12:8], act[7:0], exp[12:8], exp[7:0]);
    end
  endtask

  initial begin
    logic [12:0] e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        compare(0, {c10_0, c20_0, e1o_0, e2o_0, busy_0, credit_0}, e);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        compare(1, {c10_1, c20_1, e1o_1, e2o_1, busy_1, credit_1}, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit k1, k2, kw, kr;
    rst = 1; eu1 = 0; eu2 = 0; wt = 0;
    p1 = 0; p2 = 0; pw = 0;
    for (int d = 0; d < 2; d++) begin
      m_credit[d] = 0; m_act[d] = 0; m_busy[d] = 0; m_t0[d] = 0; m_base[d] = 0;
      m_n10a[d] = 0; m_n20[d] = 0; m_n10b[d] = 0;
    end
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    idle(2);
    // EU1 held three cycles counts once, then change
    step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
    idle(1);
    step(0, 0, 0, 1);
    idle(20);
    // EU2 then EU1 then change
    step(0, 0, 1, 0); idle(1);
    step(0, 1, 0, 0); idle(1);
    step(0, 0, 0, 1);
    idle(40);
    // two EU2 coins: the small-limit instance must return the second
    step(1, 0, 0, 0);
    step(0, 0, 1, 0); idle(1);
    step(0, 0, 1, 0); idle(2);
    // simultaneous EU1+EU2 from zero, then coin and WT during payout
    step(1, 0, 0, 0);
    step(0, 1, 1, 0); idle(1);
    step(0, 0, 0, 1); idle(2);
    step(0, 1, 0, 0); idle(1);
    step(0, 0, 0, 1);
    idle(40);
    // reset in the middle of a payout
    step(0, 1, 0, 0); idle(1);
    step(0, 0, 0, 1); idle(6);
    step(1, 0, 0, 0);
    idle(10);
    // randomized key traffic
    for (int i = 0; i < 3000; i++) begin
      k1 = ($urandom_range(0, 4) == 0);
      k2 = ($urandom_range(0, 5) == 0);
      kw = ($urandom_range(0, 9) == 0);
      kr = ($urandom_range(0, 399) == 0);
      step(kr, k1, k2, kw);
    end
    idle(80);
    @(negedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expected records left, required 0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
